// File: rtl/life_gen.sv
// life_gen: generation engine for the Life board.
// Walks the cell-address sweep from the board counter and computes each
// visited cell's next state from the visible board (cur). The results are
// collected in nxt. At the last address nxt is committed to cur, and the
// generation count and population are published.
// Outside a sweep the module serves single-cell toggles at the cursor
// address and returns the addressed cell for display.
module life_gen #(
    parameter int             X     = 8,
    parameter int             Y     = 8,
    parameter int             LOG2X = 3,
    parameter int             LOG2Y = 3,
    parameter logic [X*Y-1:0] INIT  = 64'h0000_0000_0007_0402,
    parameter int             GEN_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LOG2X+LOG2Y-1:0] addr,
    input  logic                   step,
    input  logic                   toggle,
    output logic                   cell_out,
    output logic                   gen_done,
    output logic [GEN_W-1:0]       gen_cnt,
    output logic [LOG2X+LOG2Y:0]   pop
);

    localparam int                   N    = X * Y;
    localparam int                   AW   = LOG2X + LOG2Y;
    localparam logic [AW-1:0]        LAST = AW'(N - 1);
    localparam logic [GEN_W-1:0]     GEN_ONE = GEN_W'(1);

    logic [N-1:0]      cur;
    logic [N-1:0]      nxt;
    logic [AW:0]       pop_acc;

    logic [LOG2X-1:0]  ax, xm, xp;
    logic [LOG2Y-1:0]  ay, ym, yp;
    logic [7:0]        nbr;
    logic [3:0]        n;
    logic              self_live;
    logic              new_cell;
    logic              at_last;
    logic [AW:0]       new_ext;
    logic [N-1:0]      commit_board;

    // Split the address and form the toroidal neighbour coordinates.
    // The index widths are exact powers of two, so +-1 wraps on its own.
    always_comb begin
        ax = addr[LOG2X-1:0];
        ay = addr[AW-1:LOG2X];
        xm = ax - 1'b1;
        xp = ax + 1'b1;
        ym = ay - 1'b1;
        yp = ay + 1'b1;
    end

    // Gather the 8 neighbours from the visible board only, so that
    // writes made during the sweep never feed back into the evaluation.
    always_comb begin
        nbr[0] = cur[{ym, xm}];
        nbr[1] = cur[{ym, ax}];
        nbr[2] = cur[{ym, xp}];
        nbr[3] = cur[{ay, xm}];
        nbr[4] = cur[{ay, xp}];
        nbr[5] = cur[{yp, xm}];
        nbr[6] = cur[{yp, ax}];
        nbr[7] = cur[{yp, xp}];
        self_live = cur[addr];
    end

    // Neighbour popcount and the birth/survival rule.
    always_comb begin
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, nbr[i]};
        end
        new_cell = (n == 4'd3) | (self_live & (n == 4'd2));
        new_ext  = {{AW{1'b0}}, new_cell};
        at_last  = (addr == LAST);
    end

    // Board committed at the last address: the accumulated nxt with the
    // final cell taken straight from this cycle's evaluation.
    always_comb begin
        commit_board       = nxt;
        commit_board[LAST] = new_cell;
    end

    // Board state: sweep writes into nxt, commit into cur, edits into both.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur <= INIT;
            nxt <= INIT;
        end else if (step) begin
            if (at_last) begin
                cur       <= commit_board;
                nxt[LAST] <= new_cell;
            end else begin
                nxt[addr] <= new_cell;
            end
        end else if (toggle) begin
            cur[addr] <= ~self_live;
            nxt[addr] <= ~self_live;
        end
    end

    // Population accumulation, generation count and the commit pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_acc  <= '0;
            pop      <= '0;
            gen_cnt  <= '0;
            gen_done <= 1'b0;
        end else begin
            gen_done <= 1'b0;
            if (step) begin
                if (at_last) begin
                    pop      <= pop_acc + new_ext;
                    pop_acc  <= '0;
                    gen_cnt  <= gen_cnt + GEN_ONE;
                    gen_done <= 1'b1;
                end else begin
                    pop_acc  <= pop_acc + new_ext;
                end
            end
        end
    end

    // Display readback of the addressed cell, as it was before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cell_out <= 1'b0;
        end else begin
            cell_out <= self_live;
        end
    end

endmodule

// File: tb/tb_life_gen.sv
// tb_life_gen: directed bench for life_gen.
// Three instances share one stimulus stream: the default glider board, an
// empty board (INIT=0) for the edit scenarios, and a GEN_W=4 build for the
// generation-counter wrap. Boards are read back cell by cell via cell_out.
module tb_life_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] addr = '0;
    logic       step = 1'b0;
    logic       toggle = 1'b0;

    logic        cell_g, done_g;
    logic [15:0] gen_g;
    logic [6:0]  pop_g;

    logic        cell_e, done_e;
    logic [15:0] gen_e;
    logic [6:0]  pop_e;

    logic        cell_w, done_w;
    logic [3:0]  gen_w;
    logic [6:0]  pop_w;

    int total = 0;
    int fails = 0;
    int pulses_g = 0;
    int pulses_w = 0;

    logic [63:0] board_g, board_e, board_w;

    localparam logic [63:0] GLIDER     = 64'h0000_0000_0007_0402;
    localparam logic [63:0] GLIDER_G1  = 64'h0000_0000_0206_0500;
    localparam logic [63:0] GLIDER_G4  = 64'h0000_0000_0E08_0400;

    always #5 clk = ~clk;

    life_gen dut_g (
        .clk(clk), .reset(reset), .addr(addr), .step(step), .toggle(toggle),
        .cell_out(cell_g), .gen_done(done_g), .gen_cnt(gen_g), .pop(pop_g)
    );

    life_gen #(.INIT(64'h0)) dut_e (
        .clk(clk), .reset(reset), .addr(addr), .step(step), .toggle(toggle),
        .cell_out(cell_e), .gen_done(done_e), .gen_cnt(gen_e), .pop(pop_e)
    );

    life_gen #(.GEN_W(4)) dut_w (
        .clk(clk), .reset(reset), .addr(addr), .step(step), .toggle(toggle),
        .cell_out(cell_w), .gen_done(done_w), .gen_cnt(gen_w), .pop(pop_w)
    );

    // Count commit pulses away from the active edge.
    always @(negedge clk) begin
        if (done_g) pulses_g++;
        if (done_w) pulses_w++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 'h%0h, want 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; step = 1'b0; toggle = 1'b0;
        tick();
        reset = 1'b0;
        pulses_g = 0;
        pulses_w = 0;
    endtask

    task automatic sweep();
        toggle = 1'b0;
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a);
            step = 1'b1;
            tick();
        end
        step = 1'b0;
    endtask

    task automatic tog(input int a);
        addr = 6'(a); toggle = 1'b1; step = 1'b0;
        tick();
        toggle = 1'b0;
    endtask

    task automatic readout();
        step = 1'b0; toggle = 1'b0;
        for (int a = 0; a < 64; a++) begin
            addr = 6'(a);
            tick();
            board_g[a] = cell_g;
            board_e[a] = cell_e;
            board_w[a] = cell_w;
        end
    endtask

    initial begin
        #2;
        // Reset state.
        do_reset();
        check("rst_gen",      64'(gen_g),  64'd0);
        check("rst_pop",      64'(pop_g),  64'd0);
        check("rst_done",     64'(done_g), 64'd0);
        check("rst_cell",     64'(cell_g), 64'd0);
        readout();
        check("rst_board",    board_g, GLIDER);
        check("rst_board_e",  board_e, 64'h0);

        // Scenario 1: four generations of the glider.
        do_reset();
        sweep();
        check("g1_done",      64'(done_g), 64'd1);
        check("g1_gen",       64'(gen_g),  64'd1);
        sweep(); sweep(); sweep();
        check("g4_gen",       64'(gen_g),  64'd4);
        check("g4_pop",       64'(pop_g),  64'd5);
        check("g4_gen_w",     64'(gen_w),  64'd4);
        readout();
        check("g4_pulses",    64'(pulses_g), 64'd4);
        check("g4_done_low",  64'(done_g), 64'd0);
        check("g4_board",     board_g, GLIDER_G4);
        check("g4_board_e",   board_e, 64'h0);
        check("g4_pop_e",     64'(pop_e),  64'd0);

        // Scenario 2: blinker on the empty board.
        do_reset();
        tog(19); tog(27); tog(35);
        check("blk_pop_edit", 64'(pop_e),  64'd0);
        sweep();
        readout();
        check("blk1_board",   board_e, 64'h0000_0000_1C00_0000);
        check("blk1_pop",     64'(pop_e),  64'd3);
        sweep();
        readout();
        check("blk2_board",   board_e, 64'h0000_0008_0808_0000);
        check("blk2_pop",     64'(pop_e),  64'd3);

        // Scenario 3: corner L becomes a block across the wrap corner.
        do_reset();
        tog(0); tog(1); tog(8);
        sweep();
        readout();
        check("corner_board", board_e, 64'h0000_0000_0000_0303);
        check("corner_pop",   64'(pop_e),  64'd4);

        // Scenario 4: step beats toggle; toggle alone flips the cell.
        do_reset();
        addr = 6'd5; step = 1'b1; toggle = 1'b1;
        tick();
        step = 1'b0; toggle = 1'b0;
        tick();
        check("st_tog_cell",  64'(cell_e), 64'd0);
        tog(5);
        check("tog_lat_old",  64'(cell_e), 64'd0);
        tick();
        check("tog_cell",     64'(cell_e), 64'd1);
        check("tog_pop",      64'(pop_e),  64'd0);
        check("tog_gen",      64'(gen_e),  64'd0);

        // Scenario 5: reset in the middle of a sweep.
        do_reset();
        sweep();
        for (int a = 0; a < 30; a++) begin
            addr = 6'(a); step = 1'b1;
            tick();
        end
        addr = 6'd30; step = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; step = 1'b0;
        check("mid_gen",      64'(gen_g),  64'd0);
        check("mid_pop",      64'(pop_g),  64'd0);
        check("mid_done",     64'(done_g), 64'd0);
        readout();
        check("mid_board",    board_g, GLIDER);
        sweep();
        check("mid_g1_gen",   64'(gen_g),  64'd1);
        check("mid_g1_pop",   64'(pop_g),  64'd5);
        readout();
        check("mid_g1_board", board_g, GLIDER_G1);

        // Scenario 6: 4-bit generation counter wraps after 16 commits.
        do_reset();
        for (int s = 0; s < 15; s++) sweep();
        check("wrap_pre_w",   64'(gen_w),  64'd15);
        sweep();
        check("wrap_done_w",  64'(done_w), 64'd1);
        check("wrap_gen_w",   64'(gen_w),  64'd0);
        check("wrap_gen_g",   64'(gen_g),  64'd16);
        tick();
        check("wrap_pulses",  64'(pulses_w), 64'd16);
        check("wrap_pop_w",   64'(pop_w),  64'd5);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
